// File: rtl/stack_pkg.sv
// stack_pkg: shared definitions for the stack command front-end.
//   - opcode constants carried on cmd_op
//   - FSM state encoding of stack_cmd_ctrl
//   - width of the debug overflow/underflow counters
package stack_pkg;

  localparam logic [1:0] OP_ILL    = 2'b00;
  localparam logic [1:0] OP_PUSH   = 2'b01;
  localparam logic [1:0] OP_POP    = 2'b10;
  localparam logic [1:0] OP_STATUS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CAPT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int CNT_W = 8;

endpackage : stack_pkg

// File: rtl/sat_cnt.sv
// sat_cnt: up-counter that sticks at its maximum value.
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset, clears the count
//   inc_i  - increment enable (ignored once saturated)
//   cnt_o  - current count
module sat_cnt
  import stack_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : sat_cnt

// File: rtl/stack_cmd_ctrl.sv
// stack_cmd_ctrl: command front-end for a LIFO stack.
//   Command stream : cmd_valid/cmd_ready, cmd_op, cmd_data
//   Response stream: rsp_valid/rsp_ready, rsp_data, rsp_err
//   Stack pins     : stk_push/stk_pop/stk_d_in out, stk_d_out/stk_full/
//                    stk_empty/stk_tos in
//   Debug          : ovf_cnt, unf_cnt (saturating), dbg_state (FSM state)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holds valid and its payload steady until that edge;
// rsp_valid/rsp_data/rsp_err stay steady in RESP until rsp_ready is seen.
//
// Flow: IDLE accepts a command and decides from the flags sampled on that
// edge. Legal PUSH/POP go through ISSUE (one-cycle stack pulse); POP then
// spends CAPT registering stk_d_out. Everything ends in RESP.
module stack_cmd_ctrl
  import stack_pkg::*;
#(
  parameter int data_bus_width    = 8,
  parameter int address_bus_width = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [data_bus_width-1:0]    cmd_data,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [data_bus_width-1:0]    rsp_data,
  output logic                         rsp_err,
  output logic                         stk_push,
  output logic                         stk_pop,
  output logic [data_bus_width-1:0]    stk_d_in,
  input  logic [data_bus_width-1:0]    stk_d_out,
  input  logic                         stk_full,
  input  logic                         stk_empty,
  input  logic [address_bus_width-1:0] stk_tos,
  output logic [CNT_W-1:0]             ovf_cnt,
  output logic [CNT_W-1:0]             unf_cnt,
  output state_t                       dbg_state
);

  state_t                      state_q, state_d;
  logic [1:0]                  op_q, op_d;
  logic [data_bus_width-1:0]   d_in_q, d_in_d;
  logic [data_bus_width-1:0]   rsp_data_q, rsp_data_d;
  logic                        rsp_err_q, rsp_err_d;
  logic                        push_q, push_d;
  logic                        pop_q, pop_d;
  logic                        ovf_inc, unf_inc;
  logic                        accept;

  // Gated by rst_n so the stream sees "not ready" throughout reset even
  // though the state register already sits in IDLE.
  assign cmd_ready = (state_q == ST_IDLE) && rst_n;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    d_in_d     = d_in_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    push_d     = 1'b0;
    pop_d      = 1'b0;
    ovf_inc    = 1'b0;
    unf_inc    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d       = cmd_op;
          d_in_d     = cmd_data;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          unique case (cmd_op)
            OP_PUSH: begin
              if (stk_full) begin
                state_d   = ST_RESP;
                rsp_err_d = 1'b1;
                ovf_inc   = 1'b1;
              end else begin
                state_d = ST_ISSUE;
                push_d  = 1'b1;
              end
            end
            OP_POP: begin
              if (stk_empty) begin
                state_d   = ST_RESP;
                rsp_err_d = 1'b1;
                unf_inc   = 1'b1;
              end else begin
                state_d = ST_ISSUE;
                pop_d   = 1'b1;
              end
            end
            OP_STATUS: begin
              state_d = ST_RESP;
              // Top-of-stack equals depth; zero-extend into the data field.
              rsp_data_d[address_bus_width-1:0] = stk_tos;
            end
            default: begin
              state_d   = ST_RESP;
              rsp_err_d = 1'b1;
            end
          endcase
        end
      end
      ST_ISSUE: begin
        state_d = (op_q == OP_PUSH) ? ST_RESP : ST_CAPT;
      end
      ST_CAPT: begin
        // The stack presents popped data the cycle after the pop pulse.
        rsp_data_d = stk_d_out;
        rsp_err_d  = 1'b0;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_ILL;
      d_in_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      push_q     <= 1'b0;
      pop_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      d_in_q     <= d_in_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      push_q     <= push_d;
      pop_q      <= pop_d;
    end
  end

  sat_cnt #(.W(CNT_W)) u_ovf_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (ovf_inc),
    .cnt_o (ovf_cnt)
  );

  sat_cnt #(.W(CNT_W)) u_unf_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (unf_inc),
    .cnt_o (unf_cnt)
  );

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign stk_push  = push_q;
  assign stk_pop   = pop_q;
  assign stk_d_in  = d_in_q;
  assign dbg_state = state_q;

endmodule : stack_cmd_ctrl

// File: tb/tb_stack_cmd_ctrl.sv
// Bench for stack_cmd_ctrl with a behavioural LIFO attached to the stack pins.
module tb_stack_cmd_ctrl;
  import stack_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          stk_push, stk_pop;
  logic [DW-1:0] stk_d_in, stk_d_out;
  logic          stk_full, stk_empty;
  logic [AW-1:0] stk_tos;
  logic [7:0]    ovf_cnt, unf_cnt;
  state_t        dbg_state;

  always #5 clk = ~clk;

  stack_cmd_ctrl #(.data_bus_width(DW), .address_bus_width(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_d_in  (stk_d_in),
    .stk_d_out (stk_d_out),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .stk_tos   (stk_tos),
    .ovf_cnt   (ovf_cnt),
    .unf_cnt   (unf_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- stack model ----------------
  logic [DW-1:0] mem [0:15];
  logic [AW-1:0] m_tos;
  logic [DW-1:0] m_dout;
  logic          force_full, force_empty;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tos  <= '0;
      m_dout <= '0;
    end else if (stk_push) begin
      mem[m_tos] <= stk_d_in;
      m_tos      <= m_tos + 1'b1;
    end else if (stk_pop) begin
      m_dout <= mem[m_tos - 1'b1];
      m_tos  <= m_tos - 1'b1;
    end
  end

  assign stk_d_out = m_dout;
  assign stk_tos   = m_tos;
  assign stk_full  = (m_tos == 4'd15) | force_full;
  assign stk_empty = (m_tos == 4'd0)  | force_empty;

  // Pulse monitor: cycles with each strobe high, and cycles with both high.
  int push_cycles = 0;
  int pop_cycles  = 0;
  int both_cycles = 0;
  always @(negedge clk) begin
    if (stk_push) push_cycles++;
    if (stk_pop) pop_cycles++;
    if (stk_push && stk_pop) both_cycles++;
  end

  // ---------------- scoreboard ----------------
  logic [DW:0] exp_q[$];   // {err, data}
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one command and follows it to its response handshake.
  // Call at a negedge; returns at a negedge.
  task automatic send(input logic [1:0] op, input logic [DW-1:0] data,
                      input logic e_err, input logic [DW-1:0] e_data,
                      input int e_lat, input int e_push, input int e_pop,
                      input int stall);
    int lat;
    int p0, q0;
    bit ok;
    logic [DW:0] exp;
    exp_q.push_back({e_err, e_data});
    p0 = push_cycles;
    q0 = pop_cycles;
    cmd_op    = op;
    cmd_data  = data;
    cmd_valid = 1'b1;
    rsp_ready = (stall == 0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    check("cmd_ready_wait", ok, 1);
    @(posedge clk);             // accept edge
    #1 cmd_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = i; break; end
    end
    check("rsp_latency", lat, e_lat);
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        check("stall_rsp_valid", rsp_valid, 1);
        check("stall_cmd_ready", cmd_ready, 0);
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
    end
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid && rsp_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    check("rsp_handshake", ok, 1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (ok) begin
      check("rsp_data", rsp_data, exp[DW-1:0]);
      check("rsp_err", rsp_err, exp[DW]);
    end
    @(posedge clk);
    #1;
    check("rsp_valid_drop", rsp_valid, 0);
    check("cmd_ready_after", cmd_ready, 1);
    @(negedge clk);
    check("push_pulse_cycles", push_cycles - p0, e_push);
    check("pop_pulse_cycles", pop_cycles - q0, e_pop);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] data;
    logic          ffull;
    logic          fempty;
    logic          e_err;
    logic [DW-1:0] e_data;
    int            e_lat;
    int            e_push;
    int            e_pop;
    logic [7:0]    e_ovf;
    logic [7:0]    e_unf;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] op, input logic [DW-1:0] data,
                              input logic ff, input logic fe, input logic e_err,
                              input logic [DW-1:0] e_data, input int e_lat,
                              input int e_push, input int e_pop,
                              input logic [7:0] e_ovf, input logic [7:0] e_unf);
    vec_t v;
    v.op = op; v.data = data; v.ffull = ff; v.fempty = fe; v.e_err = e_err;
    v.e_data = e_data; v.e_lat = e_lat; v.e_push = e_push; v.e_pop = e_pop;
    v.e_ovf = e_ovf; v.e_unf = e_unf;
    return v;
  endfunction

  vec_t vecs [14];

  initial begin : timeout
    #400000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [DW-1:0] pushed [5];
    force_full  = 1'b0;
    force_empty = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = OP_ILL;
    cmd_data    = '0;
    rsp_ready   = 1'b1;
    rst_n       = 1'b0;

    // Reset: every output low, not ready.
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_stk_push", stk_push, 0);
    check("rst_stk_pop", stk_pop, 0);
    check("rst_stk_d_in", stk_d_in, 0);
    check("rst_ovf_cnt", ovf_cnt, 0);
    check("rst_unf_cnt", unf_cnt, 0);
    rst_n = 1'b1;
    #1 check("rel_cmd_ready", cmd_ready, 1);
    @(negedge clk);

    //               op         data   ff  fe  err data  lat push pop ovf unf
    vecs[0]  = mk(OP_PUSH,   8'h11, 0, 0, 0, 8'h00, 2, 1, 0, 0, 0);
    vecs[1]  = mk(OP_PUSH,   8'h22, 0, 0, 0, 8'h00, 2, 1, 0, 0, 0);
    vecs[2]  = mk(OP_PUSH,   8'h33, 0, 0, 0, 8'h00, 2, 1, 0, 0, 0);
    vecs[3]  = mk(OP_STATUS, 8'h00, 0, 0, 0, 8'h03, 1, 0, 0, 0, 0);
    vecs[4]  = mk(OP_POP,    8'h00, 0, 0, 0, 8'h33, 3, 0, 1, 0, 0);
    vecs[5]  = mk(OP_POP,    8'h00, 0, 0, 0, 8'h22, 3, 0, 1, 0, 0);
    vecs[6]  = mk(OP_POP,    8'h00, 0, 0, 0, 8'h11, 3, 0, 1, 0, 0);
    vecs[7]  = mk(OP_POP,    8'h00, 0, 0, 1, 8'h00, 1, 0, 0, 0, 1);
    vecs[8]  = mk(OP_ILL,    8'h5a, 0, 0, 1, 8'h00, 1, 0, 0, 0, 1);
    vecs[9]  = mk(OP_PUSH,   8'haa, 1, 0, 1, 8'h00, 1, 0, 0, 1, 1);
    vecs[10] = mk(OP_PUSH,   8'h44, 0, 0, 0, 8'h00, 2, 1, 0, 1, 1);
    vecs[11] = mk(OP_POP,    8'h00, 0, 1, 1, 8'h00, 1, 0, 0, 1, 2);
    vecs[12] = mk(OP_STATUS, 8'h00, 0, 0, 0, 8'h01, 1, 0, 0, 1, 2);
    vecs[13] = mk(OP_POP,    8'h00, 0, 0, 0, 8'h44, 3, 0, 1, 1, 2);

    for (int i = 0; i < 14; i++) begin
      force_full  = vecs[i].ffull;
      force_empty = vecs[i].fempty;
      send(vecs[i].op, vecs[i].data, vecs[i].e_err, vecs[i].e_data,
           vecs[i].e_lat, vecs[i].e_push, vecs[i].e_pop, 0);
      check("vec_ovf_cnt", ovf_cnt, vecs[i].e_ovf);
      check("vec_unf_cnt", unf_cnt, vecs[i].e_unf);
      check("vec_stk_d_in", stk_d_in, vecs[i].data);
    end
    force_full  = 1'b0;
    force_empty = 1'b0;

    // Overflow saturation: 300 more rejected pushes.
    force_full = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(OP_PUSH, 8'($urandom_range(0, 255)), 1'b1, 8'h00, 1, 0, 0, 0);
    end
    force_full = 1'b0;
    check("ovf_saturated", ovf_cnt, 8'd255);
    check("unf_unchanged", unf_cnt, 8'd2);

    // Five pushes, STATUS under 10 cycles of back-pressure, then drain.
    for (int i = 0; i < 5; i++) begin
      pushed[i] = 8'($urandom_range(0, 255));
      send(OP_PUSH, pushed[i], 1'b0, 8'h00, 2, 1, 0, 0);
    end
    send(OP_STATUS, 8'h00, 1'b0, 8'h05, 1, 0, 0, 10);
    for (int i = 4; i >= 0; i--) begin
      send(OP_POP, 8'h00, 1'b0, pushed[i], 3, 0, 1, 0);
    end

    // Reset during the ISSUE cycle of a POP.
    send(OP_PUSH, 8'h77, 1'b0, 8'h00, 2, 1, 0, 0);
    cmd_op    = OP_POP;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    check("midrst_issue_state", dbg_state, ST_ISSUE);
    check("midrst_pop_high", stk_pop, 1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_pop_async", stk_pop, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_cmd_ready", cmd_ready, 0);
    check("midrst_ovf_clear", ovf_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_state_idle", dbg_state, ST_IDLE);
    check("midrst_cmd_ready_rel", cmd_ready, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("midrst_no_rsp", rsp_valid, 0);
    end

    check("never_push_and_pop", both_cycles, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_stack_cmd_ctrl
